tri_mat_row_store: RTL and testbench
====================================

Name: tri_mat_row_store

Overview:
- Upstream neighbour of the triangular-matrix inverse stage.
- Accepts a lower-triangular complex double-precision matrix as a row-major element stream: row r carries columns 0..r only.
- Stores the matrix, then serves full rows on addressed requests. Columns above the diagonal read as zero.
- One load per matrix. The consumer releases the store to accept the next matrix.

Parameters:
- SIZE, 16, matrix dimension (rows = cols); power of two, >= 2.
- DATA_W, 64, width of one real or imaginary part (IEEE-754 double).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- elem_i  in  [1:0][DATA_W-1:0]  complex element {imag, real}
- elem_valid_i  in  1  element valid
- elem_ready_o  out  1  element accepted when valid&ready
- row_req_addr_i  in  $clog2(SIZE)  requested row index
- row_req_valid_i  in  1  row request strobe
- mat_row_o  out  [SIZE-1:0][1:0][DATA_W-1:0]  row data, index = column
- mat_row_addr_o  out  $clog2(SIZE)  row index of mat_row_o
- mat_row_valid_o  out  1  one-cycle pulse, row data valid
- mat_loaded_o  out  1  full matrix held, serving rows
- release_i  in  1  consumer done; return to load
- flush_i  in  1  abort; return to load
- busy_o  out  1  partial matrix in progress
- diag_zero_o  out  1  only with TRI_DIAG_ZERO_DETECT_EN, else tied 0
- diag_zero_row_o  out  $clog2(SIZE)  only with TRI_DIAG_ZERO_DETECT_EN, else tied 0

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is synchronous, active-low.
- Reset values:
  - State LOAD; row/col counters 0.
  - mat_row_o 0, mat_row_addr_o 0, mat_row_valid_o 0, mat_loaded_o 0, busy_o 0, diag_zero_o 0, diag_zero_row_o 0.
  - Storage contents are not reset.
- FSM states: LOAD, SERVE.
- LOAD:
  - elem_ready_o = 1.
  - On valid&ready, write elem_i to storage[row][col].
  - If col == row: col <= 0, row <= row+1. Otherwise col <= col+1.
  - Accepting element (SIZE-1, SIZE-1) moves the FSM to SERVE next cycle and zeroes both counters.
  - Total elements per matrix = SIZE*(SIZE+1)/2 (136 at default).
  - busy_o = 1 while in LOAD with (row, col) != (0, 0).
- SERVE:
  - elem_ready_o = 0; mat_loaded_o = 1.
  - A row_req_valid_i in cycle N registers in cycle N+1:
    - mat_row_o[c] = storage[addr][c] for c <= addr, else 0.
    - mat_row_addr_o = addr.
    - mat_row_valid_o = 1.
  - Latency is 1 cycle, one request per cycle, no backpressure.
  - Requests may be in any order and may repeat.
  - release_i moves the FSM to LOAD next cycle.
- Request outside SERVE: ignored; mat_row_valid_o stays 0.
- Request and release_i in the same cycle: the request is still served (valid pulse next cycle); the FSM enters LOAD.
- flush_i (any state):
  - Next cycle: LOAD, counters 0, mat_loaded_o 0, busy_o 0, mat_row_valid_o 0.
  - A request in the flush cycle is dropped.
  - flush_i has priority over release_i and over element acceptance: an element offered with flush_i is not written, and elem_ready_o stays 1.
- Upper-triangle zeroing is a read-side mask. Storage for col > row is never written and never cleared.
- Reset asserted mid-load or mid-serve behaves as flush and also clears diag flags.
- Row index wrap: after row SIZE-1 completes, the counter returns to 0. It never indexes beyond SIZE-1.

Optional Feature:
- Macro: TRI_DIAG_ZERO_DETECT_EN.
- Enabled:
  - While loading a diagonal element (col == row), test both parts for ±0: bits [62:0] of real and of imag are all zero.
  - On a hit, set sticky diag_zero_o and capture diag_zero_row_o = row, first hit only.
  - Both flags clear on flush_i, on reset, and on the first element accepted after release.
  - The matrix is still stored and served normally.
- Disabled: no detect logic; diag_zero_o and diag_zero_row_o tied to 0.

Decomposition:
- Shared package (tri_mat_pkg):
  - Complex element typedef cplx_t = struct {imag, real} of 64-bit logic.
  - State enum tri_store_state_e {LOAD, SERVE}.
  - Constant DEFAULT_SIZE = 16.
  - Function tri_elem_count(size) returning size*(size+1)/2.
- Sub-module tri_mat_load_ctr: row/col triangular counter with last-element flag; no other sub-modules.

Test Plan:
- Load SIZE=16 elements with value {imag=r, real=c} as doubles, then request rows 0..15 → row 5 returns cols 0..5 = {5.0, c}, cols 6..15 = 0. mat_row_valid_o is high exactly 1 cycle after each request. mat_loaded_o rises the cycle after element 136.
- Random elem_valid_i gaps (50% duty) → still exactly 136 handshakes before SERVE. elem_ready_o drops to 0 the cycle SERVE is entered.
- Back-to-back requests 15, 0, 15, 7 on consecutive cycles → four consecutive valid pulses with matching mat_row_addr_o. A request during LOAD produces no pulse.
- After 40 elements, assert flush_i together with elem_valid_i → element 41 is not stored and busy_o = 0 next cycle. A fresh 136-element load then serves correct data.
- release_i asserted in the same cycle as request for row 3 → row 3 is still returned. elem_ready_o = 1 next cycle. The second matrix overwrites the first: row 3 shows the new values.
- With TRI_DIAG_ZERO_DETECT_EN, diagonal (4,4) = −0.0+0.0i and (9,9) = 0 → diag_zero_o = 1, diag_zero_row_o = 4. Flags clear on the first element after release. Without the macro, both stay 0.

Source files
------------

// File: rtl/tri_mat_pkg.sv
// rtl/tri_mat_pkg.sv - shared types and helpers for the triangular matrix row store
package tri_mat_pkg;

  localparam int DEFAULT_SIZE = 16;

  // Complex double element, packed as {imag, real}
  typedef struct packed {
    logic [63:0] im;
    logic [63:0] re;
  } cplx_t;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } tri_store_state_e;

  // Number of stored elements in a lower-triangular matrix of the given size
  function automatic int tri_elem_count(input int size);
    return size * (size + 1) / 2;
  endfunction

endpackage

// File: rtl/tri_mat_load_ctr.sv
// rtl/tri_mat_load_ctr.sv - row/col counter walking a lower triangle row-major
module tri_mat_load_ctr #(
  parameter int SIZE = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    step_i,
  output logic [$clog2(SIZE)-1:0] row_o,
  output logic [$clog2(SIZE)-1:0] col_o,
  output logic                    last_o
);

  localparam int AW = $clog2(SIZE);

  logic [AW-1:0] row_q;
  logic [AW-1:0] col_q;

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == AW'(SIZE - 1)) && (col_q == AW'(SIZE - 1));

  // Advance along the row until the diagonal, then start the next row; the
  // row counter wraps to 0 after the last row since SIZE is a power of two
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (step_i) begin
      if (col_q == row_q) begin
        col_q <= '0;
        row_q <= row_q + AW'(1);
      end else begin
        col_q <= col_q + AW'(1);
      end
    end
  end

endmodule

// File: rtl/tri_mat_row_store.sv
// rtl/tri_mat_row_store.sv - lower-triangular matrix store serving full rows (option: TRI_DIAG_ZERO_DETECT_EN)
module tri_mat_row_store
  import tri_mat_pkg::*;
#(
  parameter int SIZE   = DEFAULT_SIZE,
  parameter int DATA_W = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [1:0][DATA_W-1:0]               elem_i,
  input  logic                                 elem_valid_i,
  output logic                                 elem_ready_o,
  input  logic [$clog2(SIZE)-1:0]              row_req_addr_i,
  input  logic                                 row_req_valid_i,
  output logic [SIZE-1:0][1:0][DATA_W-1:0]     mat_row_o,
  output logic [$clog2(SIZE)-1:0]              mat_row_addr_o,
  output logic                                 mat_row_valid_o,
  output logic                                 mat_loaded_o,
  input  logic                                 release_i,
  input  logic                                 flush_i,
  output logic                                 busy_o,
  output logic                                 diag_zero_o,
  output logic [$clog2(SIZE)-1:0]              diag_zero_row_o
);

  localparam int AW = $clog2(SIZE);

  tri_store_state_e state_q, state_n;
  logic [AW-1:0]    row;
  logic [AW-1:0]    col;
  logic             last;
  logic             accept;
  logic             serve_req;

  logic [1:0][DATA_W-1:0]           mem [SIZE][SIZE];
  logic [SIZE-1:0][1:0][DATA_W-1:0] row_data;

  assign elem_ready_o = (state_q == LOAD);
  assign accept       = elem_ready_o && elem_valid_i && !flush_i;
  assign mat_loaded_o = (state_q == SERVE);
  assign busy_o       = (state_q == LOAD) && ((row != '0) || (col != '0));
  assign serve_req    = (state_q == SERVE) && row_req_valid_i && !flush_i;

  tri_mat_load_ctr #(.SIZE(SIZE)) u_load_ctr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .step_i  (accept),
    .row_o   (row),
    .col_o   (col),
    .last_o  (last)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= LOAD;
    else         state_q <= state_n;
  end

  // Next state: flush wins over load completion and release
  always_comb begin
    state_n = state_q;
    if (flush_i) begin
      state_n = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (accept && last) state_n = SERVE;
        SERVE:   if (release_i)      state_n = LOAD;
        default: state_n = LOAD;
      endcase
    end
  end

  // Element storage; only lower-triangle cells are ever written
  always_ff @(posedge clk_i) begin
    if (accept) mem[row][col] <= elem_i;
  end

  // Read-side mask: columns above the diagonal read as zero
  always_comb begin
    row_data = '0;
    for (int c = 0; c < SIZE; c++) begin
      if (c <= int'(row_req_addr_i)) row_data[c] = mem[row_req_addr_i][c];
    end
  end

  // Registered row response, one cycle after the request
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mat_row_o       <= '0;
      mat_row_addr_o  <= '0;
      mat_row_valid_o <= 1'b0;
    end else begin
      mat_row_valid_o <= serve_req;
      if (serve_req) begin
        mat_row_o      <= row_data;
        mat_row_addr_o <= row_req_addr_i;
      end
    end
  end

`ifdef TRI_DIAG_ZERO_DETECT_EN
  logic diag_hit;

  assign diag_hit = accept && (col == row) &&
                    (elem_i[0][DATA_W-2:0] == '0) && (elem_i[1][DATA_W-2:0] == '0);

  // Sticky first-hit zero-diagonal flag; the first element of a load restarts it
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      diag_zero_o     <= 1'b0;
      diag_zero_row_o <= '0;
    end else if (accept && (row == '0) && (col == '0)) begin
      diag_zero_o     <= diag_hit;
      diag_zero_row_o <= '0;
    end else if (diag_hit && !diag_zero_o) begin
      diag_zero_o     <= 1'b1;
      diag_zero_row_o <= row;
    end
  end
`else
  assign diag_zero_o     = 1'b0;
  assign diag_zero_row_o = '0;
`endif

endmodule

// File: tb/tb_tri_mat_row_store.sv
// tb/tb_tri_mat_row_store.sv - directed self-checking bench for tri_mat_row_store
module tb_tri_mat_row_store;
  import tri_mat_pkg::*;

  localparam int SIZE   = 16;
  localparam int DATA_W = 64;
  localparam int AW     = $clog2(SIZE);

  logic                             clk = 1'b0;
  logic                             rst_ni = 1'b0;
  logic [1:0][DATA_W-1:0]           elem = '0;
  logic                             elem_valid = 1'b0;
  logic                             elem_ready;
  logic [AW-1:0]                    req_addr = '0;
  logic                             req_valid = 1'b0;
  logic [SIZE-1:0][1:0][DATA_W-1:0] mat_row;
  logic [AW-1:0]                    mat_row_addr;
  logic                             mat_row_valid;
  logic                             mat_loaded;
  logic                             release_r = 1'b0;
  logic                             flush = 1'b0;
  logic                             busy;
  logic                             diag_zero;
  logic [AW-1:0]                    diag_zero_row;

  int n_checks = 0;
  int n_errors = 0;
  int hs = 0;

  tri_mat_row_store #(.SIZE(SIZE), .DATA_W(DATA_W)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .elem_i          (elem),
    .elem_valid_i    (elem_valid),
    .elem_ready_o    (elem_ready),
    .row_req_addr_i  (req_addr),
    .row_req_valid_i (req_valid),
    .mat_row_o       (mat_row),
    .mat_row_addr_o  (mat_row_addr),
    .mat_row_valid_o (mat_row_valid),
    .mat_loaded_o    (mat_loaded),
    .release_i       (release_r),
    .flush_i         (flush),
    .busy_o          (busy),
    .diag_zero_o     (diag_zero),
    .diag_zero_row_o (diag_zero_row)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Element value: imag = r+off, real = c+off as doubles; zd plants zero diagonals
  function automatic cplx_t ev(input int r, input int c, input int off, input bit zd);
    cplx_t v;
    v.im = $realtobits(real'(r + off));
    v.re = $realtobits(real'(c + off));
    if (zd && r == 4 && c == 4) begin
      v.im = 64'h0;
      v.re = 64'h8000_0000_0000_0000;
    end
    if (zd && r == 9 && c == 9) v = '0;
    return v;
  endfunction

  task automatic load_elems(input int off, input int n, input bit gaps, input bit zd);
    int cnt = 0;
    for (int r = 0; r < SIZE && cnt < n; r++) begin
      for (int c = 0; c <= r && cnt < n; c++) begin
        if (gaps && $urandom_range(1, 0) == 1) begin
          elem_valid = 1'b0;
          tick();
        end
        elem       = ev(r, c, off, zd);
        elem_valid = 1'b1;
        if (r == SIZE - 1 && c == SIZE - 1) check("loaded_before_last", 128'(mat_loaded), 128'(0));
        if (elem_ready) hs++;
        tick();
        cnt++;
      end
    end
    elem_valid = 1'b0;
  endtask

  task automatic request(input int r);
    req_addr  = AW'(r);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_row(input int r, input int off, input bit zd);
    check($sformatf("valid_r%0d", r), 128'(mat_row_valid), 128'(1));
    check($sformatf("addr_r%0d", r), 128'(mat_row_addr), 128'(r));
    for (int c = 0; c < SIZE; c++) begin
      check($sformatf("row%0d_col%0d", r, c), mat_row[c],
            (c <= r) ? 128'(ev(r, c, off, zd)) : 128'(0));
    end
  endtask

  initial begin
    int seq[4];
    seq = '{15, 0, 15, 7};

    // Reset state
    tick();
    tick();
    check("rst_valid", 128'(mat_row_valid), 128'(0));
    check("rst_loaded", 128'(mat_loaded), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ready", 128'(elem_ready), 128'(1));
    check("rst_row", 128'(|mat_row), 128'(0));
    check("rst_addr", 128'(mat_row_addr), 128'(0));
    check("rst_diag", 128'(diag_zero), 128'(0));
    check("rst_diag_row", 128'(diag_zero_row), 128'(0));
    rst_ni = 1'b1;

    // Request during LOAD is ignored
    request(3);
    check("load_req_ignored", 128'(mat_row_valid), 128'(0));

    // First matrix with random gaps
    hs = 0;
    load_elems(0, tri_elem_count(SIZE), 1'b1, 1'b0);
    check("handshakes", 128'(hs), 128'(136));
    check("loaded_after_last", 128'(mat_loaded), 128'(1));
    check("ready_in_serve", 128'(elem_ready), 128'(0));
    check("busy_in_serve", 128'(busy), 128'(0));

    // Serve all rows in order
    for (int r = 0; r < SIZE; r++) begin
      request(r);
      check_row(r, 0, 1'b0);
    end
    tick();
    check("valid_idle", 128'(mat_row_valid), 128'(0));

    // Back-to-back requests
    for (int i = 0; i < 4; i++) begin
      req_addr  = AW'(seq[i]);
      req_valid = 1'b1;
      tick();
      check($sformatf("b2b_valid%0d", i), 128'(mat_row_valid), 128'(1));
      check($sformatf("b2b_addr%0d", i), 128'(mat_row_addr), 128'(seq[i]));
      check($sformatf("b2b_diag%0d", i), mat_row[seq[i]], 128'(ev(seq[i], seq[i], 0, 1'b0)));
    end
    req_valid = 1'b0;
    tick();
    check("b2b_end", 128'(mat_row_valid), 128'(0));

    // Flush in SERVE drops a concurrent request
    flush     = 1'b1;
    req_addr  = AW'(2);
    req_valid = 1'b1;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_serve_valid", 128'(mat_row_valid), 128'(0));
    check("flush_serve_loaded", 128'(mat_loaded), 128'(0));
    check("flush_serve_ready", 128'(elem_ready), 128'(1));

    // Partial load then flush with an element offered
    load_elems(50, 40, 1'b0, 1'b0);
    check("busy_partial", 128'(busy), 128'(1));
    elem       = ev(8, 4, 50, 1'b0);
    elem_valid = 1'b1;
    flush      = 1'b1;
    check("ready_with_flush", 128'(elem_ready), 128'(1));
    tick();
    elem_valid = 1'b0;
    flush      = 1'b0;
    check("busy_after_flush", 128'(busy), 128'(0));
    check("loaded_after_flush", 128'(mat_loaded), 128'(0));
    check("ready_after_flush", 128'(elem_ready), 128'(1));

    hs = 0;
    load_elems(200, tri_elem_count(SIZE), 1'b0, 1'b0);
    check("handshakes2", 128'(hs), 128'(136));
    check("loaded2", 128'(mat_loaded), 128'(1));
    request(5);
    check_row(5, 200, 1'b0);
    request(15);
    check_row(15, 200, 1'b0);

    // Release together with a request for row 3
    req_addr  = AW'(3);
    req_valid = 1'b1;
    release_r = 1'b1;
    tick();
    req_valid = 1'b0;
    release_r = 1'b0;
    check_row(3, 200, 1'b0);
    check("ready_after_release", 128'(elem_ready), 128'(1));
    check("loaded_after_release", 128'(mat_loaded), 128'(0));

    load_elems(300, tri_elem_count(SIZE), 1'b0, 1'b0);
    request(3);
    check_row(3, 300, 1'b0);

    // Zero diagonal detection
    release_r = 1'b1;
    tick();
    release_r = 1'b0;
    load_elems(1, tri_elem_count(SIZE), 1'b1, 1'b1);
`ifdef TRI_DIAG_ZERO_DETECT_EN
    check("diag_zero", 128'(diag_zero), 128'(1));
    check("diag_zero_row", 128'(diag_zero_row), 128'(4));
`else
    check("diag_zero", 128'(diag_zero), 128'(0));
    check("diag_zero_row", 128'(diag_zero_row), 128'(0));
`endif
    request(4);
    check_row(4, 1, 1'b1);
    request(9);
    check_row(9, 1, 1'b1);

    release_r = 1'b1;
    tick();
    release_r = 1'b0;
`ifdef TRI_DIAG_ZERO_DETECT_EN
    check("diag_held_after_release", 128'(diag_zero), 128'(1));
`else
    check("diag_held_after_release", 128'(diag_zero), 128'(0));
`endif
    load_elems(1, 1, 1'b0, 1'b0);
    check("diag_clear_first_elem", 128'(diag_zero), 128'(0));
    check("diag_row_clear", 128'(diag_zero_row), 128'(0));
    check("busy_one_elem", 128'(busy), 128'(1));

    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("busy_final_flush", 128'(busy), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
